// File: rtl/i2s_adc_rx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_adc_rx
// Purpose  : I2S capture deserializer for the WM8978 ADC path (aud_bclk domain)
// Revision : 1.0
// ============================================================================
module i2s_adc_rx #(
  parameter int WL    = 16,
  parameter int CNT_W = 6
) (
  input  logic                 aud_bclk,
  input  logic                 rst,
  input  logic                 aud_lrc,
  input  logic                 aud_adcdat,
  output logic signed [WL-1:0] adc_left_o,
  output logic signed [WL-1:0] adc_right_o,
  output logic                 adc_valid,
  output logic                 frame_err
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] c_WL      = CNT_W'(WL);

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_WAIT_L = 2'd1,
    S_LEFT   = 2'd2,
    S_RIGHT  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_lrc_d;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WL-1:0]    r_shift;
  logic [WL-1:0]    r_left_hold;
  logic [WL-1:0]    r_left;
  logic [WL-1:0]    r_right;
  logic             r_valid;
  logic             r_err;

  logic             w_edge;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WL-1:0]    w_shift_next;
  logic             w_full;

  // The bit sampled on an edge cycle still belongs to the slot that is ending,
  // so the length check and the captured word both include it.
  assign w_edge       = aud_lrc ^ r_lrc_d;
  assign w_cnt_next   = (r_bit_cnt == c_CNT_MAX) ? r_bit_cnt : r_bit_cnt + 1'b1;
  assign w_shift_next = (r_bit_cnt < c_WL) ? {r_shift[WL-2:0], aud_adcdat} : r_shift;
  assign w_full       = (w_cnt_next >= c_WL);

  always_ff @(posedge aud_bclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SYNC;
      r_lrc_d     <= 1'b0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_left      <= '0;
      r_right     <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_lrc_d <= aud_lrc;
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_edge) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else begin
        r_bit_cnt <= w_cnt_next;
        r_shift   <= w_shift_next;
      end

      if (w_edge) begin
        case (r_state)
          S_SYNC: begin
            r_state <= aud_lrc ? S_WAIT_L : S_LEFT;
          end
          S_WAIT_L: begin
            if (!aud_lrc) begin
              r_state <= S_LEFT;
            end
          end
          S_LEFT: begin
            if (w_full) begin
              r_left_hold <= w_shift_next;
              r_state     <= S_RIGHT;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_WAIT_L;
            end
          end
          S_RIGHT: begin
            // A short right slot drops the whole pair; held outputs stay put.
            if (w_full) begin
              r_left  <= r_left_hold;
              r_right <= w_shift_next;
              r_valid <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
            r_state <= S_LEFT;
          end
          default: begin
            r_state <= S_SYNC;
          end
        endcase
      end
    end
  end

  assign adc_left_o  = r_left;
  assign adc_right_o = r_right;
  assign adc_valid   = r_valid;
  assign frame_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_i2s_adc_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_adc_rx
// Purpose  : Slot-level reference model bench for i2s_adc_rx
// Revision : 1.0
// ============================================================================
module tb_i2s_adc_rx;

  localparam int WL    = 16;
  localparam int CNT_W = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lrc = 1'b0;
  logic          dat = 1'b0;
  logic [WL-1:0] left_o;
  logic [WL-1:0] right_o;
  logic          valid;
  logic          ferr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            ch;
    int            len;
    logic [WL-1:0] word;
  } slot_t;

  slot_t slots[$];

  i2s_adc_rx #(.WL(WL), .CNT_W(CNT_W)) dut (
    .aud_bclk   (clk),
    .rst        (rst),
    .aud_lrc    (lrc),
    .aud_adcdat (dat),
    .adc_left_o (left_o),
    .adc_right_o(right_o),
    .adc_valid  (valid),
    .frame_err  (ferr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_first(input bit ch, input int len, input logic [WL-1:0] w);
    slot_t s;
    slots.delete();
    s.ch = ch; s.len = len; s.word = w;
    slots.push_back(s);
  endtask

  // Slots are runs of constant LRC, so consecutive slots always alternate channel.
  task automatic add_next(input int len, input logic [WL-1:0] w);
    slot_t s;
    s.ch = ~slots[slots.size()-1].ch; s.len = len; s.word = w;
    slots.push_back(s);
  endtask

  task automatic run_stream(input string name);
    int            n, t, pos, b, nv_exp, nv_obs;
    int            start[];
    logic          lrc_a[];
    logic          dat_a[];
    int            ev[];
    logic [WL-1:0] ev_l[];
    logic [WL-1:0] ev_r[];
    logic [WL-1:0] hold, exp_l, exp_r;
    bit            left_ok;

    n = slots.size();
    start = new[n+1];
    t = 0;
    for (int i = 0; i < n; i++) begin
      start[i] = t;
      t += slots[i].len;
    end
    start[n] = t;
    lrc_a = new[t+1];
    dat_a = new[t+1];
    ev = new[t+1];
    ev_l = new[t+1];
    ev_r = new[t+1];
    for (int k = 0; k <= t; k++) ev[k] = 0;
    dat_a[0] = 1'($urandom);
    // I2S one-bit delay: slot bits land one bclk after the LRC run starts.
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < slots[i].len; j++) begin
        lrc_a[start[i]+j]   = slots[i].ch;
        dat_a[start[i]+1+j] = (j < WL) ? slots[i].word[WL-1-j] : 1'($urandom);
      end
    end
    lrc_a[t] = slots[n-1].ch;

    // Slot 0 is never captured; every later left slot is; a right slot pairs
    // only with an immediately preceding full-length left slot.
    left_ok = 1'b0;
    hold = '0;
    nv_exp = 0;
    for (int i = 1; i < n-1; i++) begin
      b = start[i+1];
      if (slots[i].ch == 1'b0) begin
        if (slots[i].len >= WL) begin
          hold = slots[i].word;
          left_ok = 1'b1;
        end else begin
          ev[b] = 2;
          left_ok = 1'b0;
        end
      end else begin
        if (left_ok) begin
          if (slots[i].len >= WL) begin
            ev[b] = 1; ev_l[b] = hold; ev_r[b] = slots[i].word;
            nv_exp++;
          end else begin
            ev[b] = 2;
          end
        end
        left_ok = 1'b0;
      end
    end

    @(negedge clk);
    rst = 1'b1;
    #1;
    check({name, "_rst_left"},  32'(left_o),  32'h0);
    check({name, "_rst_right"}, 32'(right_o), 32'h0);
    check({name, "_rst_valid"}, 32'(valid),   32'h0);
    check({name, "_rst_err"},   32'(ferr),    32'h0);

    exp_l = '0;
    exp_r = '0;
    nv_obs = 0;
    for (int k = 0; k <= t; k++) begin
      @(negedge clk);
      lrc = lrc_a[k];
      dat = dat_a[k];
      if (k == 0) rst = 1'b0;
      @(posedge clk);
      #1;
      if (ev[k] == 1) begin
        exp_l = ev_l[k];
        exp_r = ev_r[k];
      end
      if (valid) nv_obs++;
      check({name, "_valid"}, 32'(valid),   32'(ev[k] == 1));
      check({name, "_err"},   32'(ferr),    32'(ev[k] == 2));
      check({name, "_left"},  32'(left_o),  32'(exp_l));
      check({name, "_right"}, 32'(right_o), 32'(exp_r));
    end
    check({name, "_npairs"}, 32'(nv_obs), 32'(nv_exp));
  endtask

  initial begin
    #2;
    check("por_left",  32'(left_o),  32'h0);
    check("por_right", 32'(right_o), 32'h0);
    check("por_valid", 32'(valid),   32'h0);
    check("por_err",   32'(ferr),    32'h0);

    // Right slot first after reset, then one 32-bclk pair.
    add_first(1'b1, 20, WL'($urandom));
    add_next(32, 16'h8001);
    add_next(32, 16'h7FFE);
    add_next(32, WL'($urandom));
    run_stream("slot32");
    check("slot32_left_final",  32'(left_o),  32'h8001);
    check("slot32_right_final", 32'(right_o), 32'h7FFE);

    // Exact-length slots back to back.
    add_first(1'b0, 16, WL'($urandom));
    add_next(16, WL'($urandom));
    for (int i = 0; i < 4; i++) begin
      add_next(16, 16'hA5A5);
      add_next(16, 16'h5A5A);
    end
    add_next(16, WL'($urandom));
    run_stream("slot16");
    check("slot16_left_final",  32'(left_o),  32'hA5A5);
    check("slot16_right_final", 32'(right_o), 32'h5A5A);

    // Asynchronous reset mid-slot clears outputs before the next clock edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_left",  32'(left_o),  32'h0);
    check("async_rst_right", 32'(right_o), 32'h0);
    check("async_rst_valid", 32'(valid),   32'h0);

    // Short left slot.
    add_first(1'b1, 16, WL'($urandom));
    add_next(20, WL'($urandom));
    add_next(20, WL'($urandom));
    add_next(12, WL'($urandom));
    add_next(16, WL'($urandom));
    add_next(16, WL'($urandom));
    add_next(16, WL'($urandom));
    add_next(16, WL'($urandom));
    run_stream("shortL");

    // Short right slot after a good left.
    add_first(1'b1, 16, WL'($urandom));
    add_next(16, 16'h1234);
    add_next(10, WL'($urandom));
    add_next(16, WL'($urandom));
    add_next(16, WL'($urandom));
    add_next(16, WL'($urandom));
    run_stream("shortR");

    // Random slot lengths, including one slot longer than the counter range.
    add_first(1'($urandom), $urandom_range(1, 40), WL'($urandom));
    for (int i = 0; i < 40; i++) begin
      add_next((i == 20) ? 70 : $urandom_range(9, 40), WL'($urandom));
    end
    run_stream("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
